// File: rtl/or1200_wbmux_fwdctrl.sv
// rtl/or1200_wbmux_fwdctrl.sv - EX result mux, WB result register, RF write port and forwarding selects
//
// Purpose:
//   Picks the EX-stage result from one of four sources (muxout / ex_forw),
//   registers it into WB (muxreg / wb_forw), drives the register-file write
//   port from WB, and produces the registered per-operand forwarding selects
//   used by the ID-stage operand muxes. Select encoding: 0 RF, 1 immediate,
//   2 EX forward, 3 WB forward.
//
// Optional feature macro: OR1200_WBMUX_LOADUSE_STALL_EN
//   Defined   - load_stall flags a load in ID whose destination is read by
//               the instruction in IF, so control can insert one bubble.
//   Undefined - load_stall is tied 0; loads forward combinationally from EX.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   id/ex/wb_freeze          stage stalls (wb implies ex implies id)
//   if_addr_a/b, if_imm_b    operand addresses / immediate flag of IF instr
//   id_rd, id_rfwb_op        destination and write-back op of ID instr
//   muxin_a..muxin_d         ALU, LSU, SPR, link-address results
//   muxout                   EX result, combinational
//   muxreg, muxreg_valid     WB result and its valid flag
//   rf_we, rf_addrw, rf_dataw  register-file write port
//   sel_a, sel_b             operand selects for the next ID cycle
//   load_stall               load-use interlock request

module or1200_wbmux_fwdctrl #(
    parameter int width = 32,
    parameter int aw    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_freeze,
    input  logic             ex_freeze,
    input  logic             wb_freeze,
    input  logic [aw-1:0]    if_addr_a,
    input  logic [aw-1:0]    if_addr_b,
    input  logic             if_imm_b,
    input  logic [aw-1:0]    id_rd,
    input  logic [2:0]       id_rfwb_op,
    input  logic [width-1:0] muxin_a,
    input  logic [width-1:0] muxin_b,
    input  logic [width-1:0] muxin_c,
    input  logic [width-1:0] muxin_d,
    output logic [width-1:0] muxout,
    output logic [width-1:0] muxreg,
    output logic             muxreg_valid,
    output logic             rf_we,
    output logic [aw-1:0]    rf_addrw,
    output logic [width-1:0] rf_dataw,
    output logic [1:0]       sel_a,
    output logic [1:0]       sel_b,
    output logic             load_stall
);

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_IMM = 2'd1;
    localparam logic [1:0] SEL_EX  = 2'd2;
    localparam logic [1:0] SEL_WB  = 2'd3;

    logic [2:0]    r_ex_op;
    logic [aw-1:0] r_ex_rd;
    logic [aw-1:0] r_wb_rd;
    logic          r_wb_we;
    logic [width-1:0] r_muxreg;
    logic          r_muxreg_valid;
    logic [1:0]    r_sel_a;
    logic [1:0]    r_sel_b;

    logic [1:0]    w_sel_a_nxt;
    logic [1:0]    w_sel_b_nxt;
    // ID may not advance while EX is frozen; an advance request then is a bubble.
    logic          w_id_frz;

    assign w_id_frz = id_freeze | ex_freeze;

    // Where the producer of adr will sit next cycle if the pipe advances.
    // The ID producer is younger than the EX producer, so it wins.
    function automatic logic [1:0] f_fwd(
        input logic [aw-1:0] adr,
        input logic          id_we,
        input logic [aw-1:0] id_dst,
        input logic          ex_we,
        input logic [aw-1:0] ex_dst
    );
        if (adr == '0)
            return SEL_RF;
        else if (id_we && (id_dst == adr))
            return SEL_EX;
        else if (ex_we && (ex_dst == adr))
            return SEL_WB;
        else
            return SEL_RF;
    endfunction

    // A bubble moves every producer one stage down: EX->WB, WB->retired (RF).
    function automatic logic [1:0] f_shift(input logic [1:0] s);
        case (s)
            SEL_EX:  return SEL_WB;
            SEL_WB:  return SEL_RF;
            default: return s;
        endcase
    endfunction

    always_comb begin
        w_sel_a_nxt = r_sel_a;
        w_sel_b_nxt = r_sel_b;
        if (ex_freeze) begin
            w_sel_a_nxt = r_sel_a;
            w_sel_b_nxt = r_sel_b;
        end else if (w_id_frz) begin
            w_sel_a_nxt = f_shift(r_sel_a);
            w_sel_b_nxt = f_shift(r_sel_b);
        end else begin
            w_sel_a_nxt = f_fwd(if_addr_a, id_rfwb_op[0], id_rd, r_ex_op[0], r_ex_rd);
            w_sel_b_nxt = if_imm_b ? SEL_IMM
                                   : f_fwd(if_addr_b, id_rfwb_op[0], id_rd, r_ex_op[0], r_ex_rd);
        end
    end

    always_comb begin
        muxout = muxin_a;
        case (r_ex_op[2:1])
            2'b00:   muxout = muxin_a;
            2'b01:   muxout = muxin_b;
            2'b10:   muxout = muxin_c;
            default: muxout = muxin_d;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ex_op        <= '0;
            r_ex_rd        <= '0;
            r_wb_rd        <= '0;
            r_wb_we        <= 1'b0;
            r_muxreg       <= '0;
            r_muxreg_valid <= 1'b0;
            r_sel_a        <= SEL_RF;
            r_sel_b        <= SEL_RF;
        end else begin
            if (!ex_freeze) begin
                if (!w_id_frz) begin
                    r_ex_op <= id_rfwb_op;
                    r_ex_rd <= id_rd;
                end else begin
                    r_ex_op <= '0;
                    r_ex_rd <= '0;
                end
            end

            if (!wb_freeze) begin
                if (!ex_freeze) begin
                    r_muxreg       <= muxout;
                    r_wb_rd        <= r_ex_rd;
                    r_muxreg_valid <= r_ex_op[0];
                    r_wb_we        <= r_ex_op[0] && (r_ex_rd != '0);
                end else begin
                    r_wb_we        <= 1'b0;
                    r_muxreg_valid <= 1'b0;
                end
            end

            r_sel_a <= w_sel_a_nxt;
            r_sel_b <= w_sel_b_nxt;
        end
    end

`ifdef OR1200_WBMUX_LOADUSE_STALL_EN
    logic r_load_stall;
    logic w_ls_hit;

    assign w_ls_hit = (id_rfwb_op == 3'b011) && (id_rd != '0) &&
                      ((id_rd == if_addr_a) || (!if_imm_b && (id_rd == if_addr_b)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_load_stall <= 1'b0;
        else if (ex_freeze)
            r_load_stall <= r_load_stall;
        else if (w_id_frz)
            r_load_stall <= 1'b0;
        else
            r_load_stall <= w_ls_hit;
    end

    assign load_stall = r_load_stall;
`else
    assign load_stall = 1'b0;
`endif

    assign muxreg       = r_muxreg;
    assign muxreg_valid = r_muxreg_valid;
    assign rf_we        = r_wb_we && !wb_freeze;
    assign rf_addrw     = r_wb_rd;
    assign rf_dataw     = r_muxreg;
    assign sel_a        = r_sel_a;
    assign sel_b        = r_sel_b;

endmodule

// File: tb/tb_or1200_wbmux_fwdctrl.sv
// tb/tb_or1200_wbmux_fwdctrl.sv - self-checking bench for or1200_wbmux_fwdctrl

module tb_or1200_wbmux_fwdctrl;

    localparam int W  = 32;
    localparam int AW = 5;

`ifdef OR1200_WBMUX_LOADUSE_STALL_EN
    localparam bit LS_EN = 1'b1;
`else
    localparam bit LS_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          id_freeze, ex_freeze, wb_freeze;
    logic [AW-1:0] if_addr_a, if_addr_b, id_rd;
    logic          if_imm_b;
    logic [2:0]    id_rfwb_op;
    logic [W-1:0]  muxin_a, muxin_b, muxin_c, muxin_d;
    logic [W-1:0]  muxout, muxreg, rf_dataw;
    logic          muxreg_valid, rf_we, load_stall;
    logic [AW-1:0] rf_addrw;
    logic [1:0]    sel_a, sel_b;

    int pass_cnt  = 0;
    int total_cnt = 0;

    or1200_wbmux_fwdctrl #(.width(W), .aw(AW)) dut (
        .clk(clk), .rst(rst),
        .id_freeze(id_freeze), .ex_freeze(ex_freeze), .wb_freeze(wb_freeze),
        .if_addr_a(if_addr_a), .if_addr_b(if_addr_b), .if_imm_b(if_imm_b),
        .id_rd(id_rd), .id_rfwb_op(id_rfwb_op),
        .muxin_a(muxin_a), .muxin_b(muxin_b), .muxin_c(muxin_c), .muxin_d(muxin_d),
        .muxout(muxout), .muxreg(muxreg), .muxreg_valid(muxreg_valid),
        .rf_we(rf_we), .rf_addrw(rf_addrw), .rf_dataw(rf_dataw),
        .sel_a(sel_a), .sel_b(sel_b), .load_stall(load_stall)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic idf, input logic exf, input logic wbf,
                         input logic [AW-1:0] aa, input logic [AW-1:0] ab, input logic imm,
                         input logic [AW-1:0] rd, input logic [2:0] op);
        id_freeze  = idf;
        ex_freeze  = exf;
        wb_freeze  = wbf;
        if_addr_a  = aa;
        if_addr_b  = ab;
        if_imm_b   = imm;
        id_rd      = rd;
        id_rfwb_op = op;
    endtask

    task automatic flush();
        drive(0, 0, 0, 0, 0, 0, 0, 3'b000);
        repeat (3) tick();
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 3'b000);
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        int pulses;
        muxin_a = 32'h1234_5678;
        drive(0, 0, 0, 0, 0, 0, 5'd3, 3'b001);
        tick();
        drive(0, 0, 0, 5'd3, 0, 0, 0, 3'b000);
        tick();
        // r3 is now pending in WB; pull reset in the middle of the cycle
        #2;
        rst = 1'b0;
        #1;
        total_cnt++; if (rf_we !== 1'b0) $display("FAIL reset_rf_we got %0b want 0", rf_we); else pass_cnt++;
        total_cnt++; if (muxreg !== '0) $display("FAIL reset_muxreg got %h want 0", muxreg); else pass_cnt++;
        total_cnt++; if (muxreg_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", muxreg_valid); else pass_cnt++;
        total_cnt++; if (rf_addrw !== '0) $display("FAIL reset_addrw got %0d want 0", rf_addrw); else pass_cnt++;
        total_cnt++; if (sel_a !== 2'd0 || sel_b !== 2'd0) $display("FAIL reset_sel got %0d/%0d want 0/0", sel_a, sel_b); else pass_cnt++;
        total_cnt++; if (load_stall !== 1'b0) $display("FAIL reset_load_stall got %0b want 0", load_stall); else pass_cnt++;
        tick();
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (rf_we === 1'b1) pulses++;
            tick();
        end
        total_cnt++; if (pulses != 0) $display("FAIL reset_no_write got %0d pulses want 0", pulses); else pass_cnt++;
    endtask

    task automatic test_alu_write();
        flush();
        muxin_a = 32'hDEAD_BEEF;
        muxin_b = 32'h0;
        drive(0, 0, 0, 0, 0, 0, 5'd5, 3'b001);
        tick();
        total_cnt++; if (muxout !== 32'hDEAD_BEEF) $display("FAIL alu_muxout got %h want deadbeef", muxout); else pass_cnt++;
        drive(0, 0, 0, 0, 0, 0, 0, 3'b000);
        tick();
        total_cnt++; if (rf_we !== 1'b1) $display("FAIL alu_rf_we got %0b want 1", rf_we); else pass_cnt++;
        total_cnt++; if (rf_addrw !== 5'd5) $display("FAIL alu_rf_addrw got %0d want 5", rf_addrw); else pass_cnt++;
        total_cnt++; if (rf_dataw !== 32'hDEAD_BEEF) $display("FAIL alu_rf_dataw got %h want deadbeef", rf_dataw); else pass_cnt++;
        total_cnt++; if (muxreg_valid !== 1'b1) $display("FAIL alu_valid got %0b want 1", muxreg_valid); else pass_cnt++;
        tick();
        total_cnt++; if (rf_we !== 1'b0) $display("FAIL alu_single_write got %0b want 0", rf_we); else pass_cnt++;
    endtask

    task automatic test_forward_selects();
        flush();
        drive(0, 0, 0, 0, 0, 0, 5'd9, 3'b001);
        tick();
        drive(0, 0, 0, 5'd7, 5'd9, 0, 5'd7, 3'b001);
        tick();
        total_cnt++; if (sel_a !== 2'd2) $display("FAIL fwd_sel_a got %0d want 2", sel_a); else pass_cnt++;
        total_cnt++; if (sel_b !== 2'd3) $display("FAIL fwd_sel_b got %0d want 3", sel_b); else pass_cnt++;
        drive(0, 0, 0, 0, 0, 0, 5'd9, 3'b001);
        tick();
        drive(0, 0, 0, 5'd7, 5'd9, 1, 5'd7, 3'b001);
        tick();
        total_cnt++; if (sel_b !== 2'd1) $display("FAIL fwd_imm_sel_b got %0d want 1", sel_b); else pass_cnt++;
        total_cnt++; if (sel_a !== 2'd2) $display("FAIL fwd_imm_sel_a got %0d want 2", sel_a); else pass_cnt++;
        drive(0, 0, 0, 0, 0, 0, 0, 3'b001);
        tick();
        total_cnt++; if (sel_a !== 2'd0) $display("FAIL fwd_r0_sel_a got %0d want 0", sel_a); else pass_cnt++;
    endtask

    task automatic test_bubble_shift();
        bit seen7;
        flush();
        muxin_a = 32'h0000_0077;
        drive(0, 0, 0, 5'd7, 0, 0, 5'd7, 3'b001);
        tick();
        total_cnt++; if (sel_a !== 2'd2) $display("FAIL bubble_start got %0d want 2", sel_a); else pass_cnt++;
        seen7 = 0;
        drive(1, 0, 0, 5'd7, 0, 0, 0, 3'b000);
        tick();
        total_cnt++; if (sel_a !== 2'd3) $display("FAIL bubble_first got %0d want 3", sel_a); else pass_cnt++;
        if (rf_we === 1'b1 && rf_addrw === 5'd7 && rf_dataw === 32'h77) seen7 = 1;
        tick();
        total_cnt++; if (sel_a !== 2'd0) $display("FAIL bubble_second got %0d want 0", sel_a); else pass_cnt++;
        total_cnt++; if (!seen7) $display("FAIL bubble_r7_write got 0 want 1"); else pass_cnt++;
    endtask

    task automatic test_freeze_hold();
        int pulses;
        flush();
        muxin_a = 32'hA5A5_A5A5;
        drive(0, 0, 0, 0, 0, 0, 5'd12, 3'b001);
        tick();
        drive(0, 0, 0, 5'd12, 0, 0, 0, 3'b000);
        tick();
        drive(1, 1, 1, 5'd12, 0, 0, 0, 3'b000);
        muxin_a = 32'h0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++; if (rf_we !== 1'b0) $display("FAIL hold_rf_we[%0d] got %0b want 0", i, rf_we); else pass_cnt++;
            total_cnt++; if (muxreg !== 32'hA5A5_A5A5) $display("FAIL hold_muxreg[%0d] got %h want a5a5a5a5", i, muxreg); else pass_cnt++;
            total_cnt++; if (sel_a !== 2'd3) $display("FAIL hold_sel_a[%0d] got %0d want 3", i, sel_a); else pass_cnt++;
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 3'b000);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (rf_we === 1'b1) pulses++;
            tick();
        end
        total_cnt++; if (pulses != 1) $display("FAIL hold_release_pulses got %0d want 1", pulses); else pass_cnt++;
    endtask

    task automatic test_load_use();
        flush();
        drive(0, 0, 0, 0, 5'd4, 0, 5'd4, 3'b011);
        tick();
        total_cnt++; if (load_stall !== LS_EN) $display("FAIL lu_stall got %0b want %0b", load_stall, LS_EN); else pass_cnt++;
        total_cnt++; if (sel_b !== 2'd2) $display("FAIL lu_sel_b got %0d want 2", sel_b); else pass_cnt++;
        drive(1, 0, 0, 0, 5'd4, 0, 0, 3'b000);
        tick();
        total_cnt++; if (sel_b !== 2'd3) $display("FAIL lu_bubble_sel_b got %0d want 3", sel_b); else pass_cnt++;
        total_cnt++; if (load_stall !== 1'b0) $display("FAIL lu_stall_clear got %0b want 0", load_stall); else pass_cnt++;
    endtask

    // Reference model: describes which instruction sits in EX and WB and
    // where the producer of each IF operand will be found next cycle.
    typedef struct {
        logic [2:0]    op;
        logic [AW-1:0] rd;
    } ex_slot_t;

    typedef struct {
        bit            writes;
        bit            valid;
        logic [AW-1:0] rd;
        logic [W-1:0]  data;
    } wb_slot_t;

    task automatic test_random();
        ex_slot_t     ex_s;
        wb_slot_t     wb_s;
        logic [1:0]   e_sa, e_sb;
        bit           e_ls;
        logic [W-1:0] src [4];
        logic [W-1:0] e_mux;
        bit           wbf, exf, idf, idf_e;
        logic [AW-1:0] aa, ab, rd;
        logic [2:0]   op;
        bit           imm;
        int           where_a, where_b;

        do_reset();
        ex_s = '{op: 3'b000, rd: '0};
        wb_s = '{writes: 0, valid: 0, rd: '0, data: '0};
        e_sa = 0; e_sb = 0; e_ls = 0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            wbf = ($urandom % 8) == 0;
            exf = wbf || (($urandom % 6) == 0);
            idf = exf || (($urandom % 5) == 0);
            if (exf && (($urandom % 4) == 0)) idf = 0;
            aa  = AW'($urandom % 8);
            ab  = AW'($urandom % 8);
            rd  = AW'($urandom % 8);
            op  = 3'($urandom);
            imm = ($urandom % 4) == 0;
            muxin_a = $urandom; muxin_b = $urandom; muxin_c = $urandom; muxin_d = $urandom;
            drive(idf, exf, wbf, aa, ab, imm, rd, op);
            #1;

            src[0] = muxin_a; src[1] = muxin_b; src[2] = muxin_c; src[3] = muxin_d;
            e_mux = src[int'(ex_s.op) / 2];

            total_cnt++; if (muxout !== e_mux) $display("FAIL rnd_muxout cyc %0d got %h want %h", cyc, muxout, e_mux); else pass_cnt++;
            total_cnt++; if (rf_we !== (wb_s.writes && !wbf)) $display("FAIL rnd_rf_we cyc %0d got %0b want %0b", cyc, rf_we, wb_s.writes && !wbf); else pass_cnt++;
            total_cnt++; if (rf_addrw !== wb_s.rd) $display("FAIL rnd_rf_addrw cyc %0d got %0d want %0d", cyc, rf_addrw, wb_s.rd); else pass_cnt++;
            total_cnt++; if (rf_dataw !== wb_s.data) $display("FAIL rnd_rf_dataw cyc %0d got %h want %h", cyc, rf_dataw, wb_s.data); else pass_cnt++;
            total_cnt++; if (muxreg_valid !== wb_s.valid) $display("FAIL rnd_valid cyc %0d got %0b want %0b", cyc, muxreg_valid, wb_s.valid); else pass_cnt++;
            total_cnt++; if (sel_a !== e_sa) $display("FAIL rnd_sel_a cyc %0d got %0d want %0d", cyc, sel_a, e_sa); else pass_cnt++;
            total_cnt++; if (sel_b !== e_sb) $display("FAIL rnd_sel_b cyc %0d got %0d want %0d", cyc, sel_b, e_sb); else pass_cnt++;
            total_cnt++; if (load_stall !== e_ls) $display("FAIL rnd_load_stall cyc %0d got %0b want %0b", cyc, load_stall, e_ls); else pass_cnt++;

            idf_e = idf || exf;

            // load interlock: a load in ID whose result the IF instruction reads
            if (LS_EN) begin
                if (exf) e_ls = e_ls;
                else if (idf_e) e_ls = 0;
                else e_ls = (op == 3'b011) && (rd != 0) && ((rd == aa) || (!imm && rd == ab));
            end

            // forwarding selects: locate each operand's producer one cycle ahead
            if (!exf) begin
                if (idf_e) begin
                    e_sa = (e_sa == 2) ? 2'd3 : (e_sa == 3) ? 2'd0 : e_sa;
                    e_sb = (e_sb == 2) ? 2'd3 : (e_sb == 3) ? 2'd0 : e_sb;
                end else begin
                    where_a = 0;
                    if (aa != 0 && ex_s.op[0] && ex_s.rd == aa) where_a = 3;
                    if (aa != 0 && op[0] && rd == aa) where_a = 2;
                    where_b = 0;
                    if (ab != 0 && ex_s.op[0] && ex_s.rd == ab) where_b = 3;
                    if (ab != 0 && op[0] && rd == ab) where_b = 2;
                    e_sa = 2'(where_a);
                    e_sb = imm ? 2'd1 : 2'(where_b);
                end
            end

            if (!wbf) begin
                if (exf) begin
                    wb_s.writes = 0;
                    wb_s.valid  = 0;
                end else begin
                    wb_s.writes = ex_s.op[0] && (ex_s.rd != 0);
                    wb_s.valid  = ex_s.op[0];
                    wb_s.rd     = ex_s.rd;
                    wb_s.data   = e_mux;
                end
            end

            if (!exf) begin
                if (idf_e) ex_s = '{op: 3'b000, rd: '0};
                else       ex_s = '{op: op, rd: rd};
            end

            tick();
        end
    endtask

    initial begin
        rst = 1'b0;
        muxin_a = '0; muxin_b = '0; muxin_c = '0; muxin_d = '0;
        drive(0, 0, 0, 0, 0, 0, 0, 3'b000);
        tick();
        tick();
        rst = 1'b1;
        tick();
        test_reset();
        test_alu_write();
        test_forward_selects();
        test_bubble_shift();
        test_freeze_hold();
        test_load_use();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/or1200_wbmux_fwdctrl.md
Name: or1200_wbmux_fwdctrl

Overview:
Write-back side of the operand-forwarding interface. The block selects the EX-stage result from four sources and drives it as ex_forw (muxout). It registers that result into the WB stage as wb_forw (muxreg) and drives the register-file write port. It also produces the registered per-operand select codes sel_a/sel_b consumed by the ID-stage operand muxes. The forwarding encodings are fixed: 0 = RF, 1 = immediate, 2 = EX forward, 3 = WB forward.

Parameters:
width, 32, datapath width (matches OR1200_OPERAND_WIDTH)
aw, 5, register address width

Ports:
clk  in  1  core clock
rst  in  1  reset; asynchronous, active-low (asserted when rst==0)
id_freeze  in  1  ID stage stalled
ex_freeze  in  1  EX stage stalled (implies id_freeze)
wb_freeze  in  1  WB stage stalled (implies ex_freeze)
if_addr_a  in  aw  RF read address A presented in IF
if_addr_b  in  aw  RF read address B presented in IF
if_imm_b  in  1  IF instruction uses immediate for operand B
id_rd  in  aw  destination register of ID instruction
id_rfwb_op  in  3  [0] write enable, [2:1] source: 00 ALU, 01 LSU, 10 SPR, 11 link
muxin_a..muxin_d  in  width  ALU, LSU, SPR, link-address results
muxout  out  width  EX result (ex_forw), combinational
muxreg  out  width  WB result (wb_forw), registered
muxreg_valid  out  1  muxreg holds a writing instruction
rf_we  out  1  RF write enable
rf_addrw  out  aw  RF write address
rf_dataw  out  width  RF write data (= muxreg)
sel_a  out  2  operand A select for next ID cycle
sel_b  out  2  operand B select for next ID cycle
load_stall  out  1  load-use interlock request (see Optional Feature)

Behaviour:
- Reset (rst==0, async): ex_op=0, ex_rd=0, wb_rd=0, wb_we=0, muxreg=0, muxreg_valid=0, sel_a=0, sel_b=0, load_stall=0. Reset mid-operation discards in-flight writes; no rf_we is issued.
- EX register:
  - !ex_freeze && !id_freeze: ex_op<=id_rfwb_op, ex_rd<=id_rd.
  - !ex_freeze && id_freeze: bubble, ex_op<=0, ex_rd<=0.
  - ex_freeze: hold.
- muxout: combinational case on ex_op[2:1]; 0 latency from muxin_*.
- WB register:
  - !wb_freeze && !ex_freeze: muxreg<=muxout, wb_rd<=ex_rd, muxreg_valid<=ex_op[0], wb_we<=ex_op[0] && ex_rd!=0.
  - !wb_freeze && ex_freeze: bubble, wb_we<=0, muxreg_valid<=0, muxreg held.
  - wb_freeze: hold all.
- RF port: rf_we = wb_we && !wb_freeze; rf_addrw = wb_rd; rf_dataw = muxreg. At most one write per cycle; r0 is never written. The RF returns new data on same-cycle read/write to the same address.
- sel update, normal advance (!id_freeze), per operand X with address adr:
  - X==B and if_imm_b: 1.
  - Else adr!=0 && id_rfwb_op[0] && id_rd==adr: 2 (producer enters EX). This takes priority over the WB match.
  - Else adr!=0 && ex_op[0] && ex_rd==adr: 3 (producer enters WB).
  - Else 0.
- sel update, id_freeze && !ex_freeze (bubble into EX): producers move one stage. sel 2->3, 3->0, 1 and 0 unchanged.
- sel update, ex_freeze: hold sel_a, sel_b.
- !id_freeze with ex_freeze=1 is illegal; the block treats it as id_freeze=1.

Optional Feature:
Macro OR1200_WBMUX_LOADUSE_STALL_EN.
- Defined: on advance (!id_freeze), load_stall<=1 when id_rfwb_op==3'b011, id_rd!=0, and id_rd matches if_addr_a, or matches if_addr_b with !if_imm_b. Otherwise load_stall<=0. Under ex_freeze, load_stall holds. Under id_freeze && !ex_freeze, load_stall<=0. External control raises id_freeze for that one cycle, so the bubble rule converts sel 2->3 and the load result arrives via wb_forw.
- Undefined: load_stall tied 0. Loads forward from EX through muxout combinationally from muxin_b.

Test Plan:
- Reset: rst=0 mid-stream with wb_we pending -> all outputs 0, no rf_we pulse after rst=1.
- ALU write: id_rd=5, op=3'b001, muxin_a=32'hDEAD_BEEF, no freezes -> muxout=DEADBEEF one cycle later; rf_we=1, rf_addrw=5, rf_dataw=DEADBEEF two cycles later.
- Forward selects: ID writes r7, EX writes r9, if_addr_a=7, if_addr_b=9 -> next cycle sel_a=2, sel_b=3. Same with if_imm_b=1 -> sel_b=1. if_addr_a=0 with id_rd=0 -> sel_a=0.
- Bubble shift: sel_a=2, then id_freeze=1, ex_freeze=0 -> sel_a=3. Repeat -> sel_a=0, and the r7 write has been issued on rf_we.
- Freeze hold: wb_freeze=ex_freeze=id_freeze=1 for 3 cycles with wb_we=1 -> rf_we=0, muxreg/sel stable. On release, exactly one rf_we pulse.
- Load-use (macro on): ID load op=3'b011 to r4, if_addr_b=4, if_imm_b=0 -> load_stall=1 next cycle and sel_b=2. After one id_freeze cycle, sel_b=3 and load_stall=0. With macro off -> load_stall stays 0.
